wimpfi_crc8_engine: RTL and testbench

- Dual CRC-8 generator/checker for the WimpFi link layer.
- Contains a bit-serial engine (one bit per enabled clock) and a byte-parallel, table-driven engine (one byte per enabled clock). Both compute the identical CRC over the same LSB-first bit stream.
- The transmitter appends the bit-serial result. The receiver checks for a zero residue.
- The byte engine is the fast path and cross-checks the bit engine.

---
 rtl/wimpfi_crc8_engine.sv | 86 ++++++++
 tb/tb_wimpfi_crc8_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wimpfi_crc8_engine.sv
// rtl/wimpfi_crc8_engine.sv - WimpFi dual CRC-8 engine (bit-serial + table-driven byte); optional macro CRC_ZERO_FLAG_EN
module wimpfi_crc8_engine #(
    parameter logic [7:0] CRC_INIT  = 8'h00,
    parameter logic [7:0] POLY_REFL = 8'hE0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_enb,
    input  logic       bit_d,
    input  logic       byte_enb,
    input  logic [7:0] byte_data,
    output logic [7:0] crc_bit,
    output logic [7:0] crc_byte
`ifdef CRC_ZERO_FLAG_EN
    ,
    output logic       crc_bit_ok,
    output logic       crc_byte_ok
`endif
);

    // Eight zero-input bit steps from each index; valid only for POLY_REFL = 8'hE0.
    localparam logic [7:0] CRC_TABLE [0:255] = '{
        8'h00, 8'h91, 8'hE3, 8'h72, 8'h07, 8'h96, 8'hE4, 8'h75, 8'h0E, 8'h9F, 8'hED, 8'h7C, 8'h09, 8'h98, 8'hEA, 8'h7B,
        8'h1C, 8'h8D, 8'hFF, 8'h6E, 8'h1B, 8'h8A, 8'hF8, 8'h69, 8'h12, 8'h83, 8'hF1, 8'h60, 8'h15, 8'h84, 8'hF6, 8'h67,
        8'h38, 8'hA9, 8'hDB, 8'h4A, 8'h3F, 8'hAE, 8'hDC, 8'h4D, 8'h36, 8'hA7, 8'hD5, 8'h44, 8'h31, 8'hA0, 8'hD2, 8'h43,
        8'h24, 8'hB5, 8'hC7, 8'h56, 8'h23, 8'hB2, 8'hC0, 8'h51, 8'h2A, 8'hBB, 8'hC9, 8'h58, 8'h2D, 8'hBC, 8'hCE, 8'h5F,
        8'h70, 8'hE1, 8'h93, 8'h02, 8'h77, 8'hE6, 8'h94, 8'h05, 8'h7E, 8'hEF, 8'h9D, 8'h0C, 8'h79, 8'hE8, 8'h9A, 8'h0B,
        8'h6C, 8'hFD, 8'h8F, 8'h1E, 8'h6B, 8'hFA, 8'h88, 8'h19, 8'h62, 8'hF3, 8'h81, 8'h10, 8'h65, 8'hF4, 8'h86, 8'h17,
        8'h48, 8'hD9, 8'hAB, 8'h3A, 8'h4F, 8'hDE, 8'hAC, 8'h3D, 8'h46, 8'hD7, 8'hA5, 8'h34, 8'h41, 8'hD0, 8'hA2, 8'h33,
        8'h54, 8'hC5, 8'hB7, 8'h26, 8'h53, 8'hC2, 8'hB0, 8'h21, 8'h5A, 8'hCB, 8'hB9, 8'h28, 8'h5D, 8'hCC, 8'hBE, 8'h2F,
        8'hE0, 8'h71, 8'h03, 8'h92, 8'hE7, 8'h76, 8'h04, 8'h95, 8'hEE, 8'h7F, 8'h0D, 8'h9C, 8'hE9, 8'h78, 8'h0A, 8'h9B,
        8'hFC, 8'h6D, 8'h1F, 8'h8E, 8'hFB, 8'h6A, 8'h18, 8'h89, 8'hF2, 8'h63, 8'h11, 8'h80, 8'hF5, 8'h64, 8'h16, 8'h87,
        8'hD8, 8'h49, 8'h3B, 8'hAA, 8'hDF, 8'h4E, 8'h3C, 8'hAD, 8'hD6, 8'h47, 8'h35, 8'hA4, 8'hD1, 8'h40, 8'h32, 8'hA3,
        8'hC4, 8'h55, 8'h27, 8'hB6, 8'hC3, 8'h52, 8'h20, 8'hB1, 8'hCA, 8'h5B, 8'h29, 8'hB8, 8'hCD, 8'h5C, 8'h2E, 8'hBF,
        8'h90, 8'h01, 8'h73, 8'hE2, 8'h97, 8'h06, 8'h74, 8'hE5, 8'h9E, 8'h0F, 8'h7D, 8'hEC, 8'h99, 8'h08, 8'h7A, 8'hEB,
        8'h8C, 8'h1D, 8'h6F, 8'hFE, 8'h8B, 8'h1A, 8'h68, 8'hF9, 8'h82, 8'h13, 8'h61, 8'hF0, 8'h85, 8'h14, 8'h66, 8'hF7,
        8'hA8, 8'h39, 8'h4B, 8'hDA, 8'hAF, 8'h3E, 8'h4C, 8'hDD, 8'hA6, 8'h37, 8'h45, 8'hD4, 8'hA1, 8'h30, 8'h42, 8'hD3,
        8'hB4, 8'h25, 8'h57, 8'hC6, 8'hB3, 8'h22, 8'h50, 8'hC1, 8'hBA, 8'h2B, 8'h59, 8'hC8, 8'hBD, 8'h2C, 8'h5E, 8'hCF
    };

    logic       fb;
    logic [7:0] bit_next;
    logic [7:0] byte_next;

    // Bit engine next value: shift right, fold in the reflected polynomial on feedback.
    always_comb begin
        fb       = bit_d ^ crc_bit[0];
        bit_next = crc_bit;
        if (bit_enb) begin
            bit_next = (crc_bit >> 1) ^ (fb ? POLY_REFL : 8'h00);
        end
    end

    // Byte engine next value: one table lookup per enabled byte; data is ignored when idle.
    always_comb begin
        byte_next = crc_byte;
        if (byte_enb) begin
            byte_next = CRC_TABLE[crc_byte ^ byte_data];
        end
    end

    // CRC registers; reset aborts any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_bit  <= CRC_INIT;
            crc_byte <= CRC_INIT;
        end else begin
            crc_bit  <= bit_next;
            crc_byte <= byte_next;
        end
    end

`ifdef CRC_ZERO_FLAG_EN
    // Zero-residue flags, updated on the same edge as their CRC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_bit_ok  <= (CRC_INIT == 8'h00);
            crc_byte_ok <= (CRC_INIT == 8'h00);
        end else begin
            crc_bit_ok  <= (bit_next == 8'h00);
            crc_byte_ok <= (byte_next == 8'h00);
        end
    end
`endif

endmodule

// File: tb/tb_wimpfi_crc8_engine.sv
// tb/tb_wimpfi_crc8_engine.sv - self-checking bench for wimpfi_crc8_engine
module tb_wimpfi_crc8_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_enb;
    logic       bit_d;
    logic       byte_enb;
    logic [7:0] byte_data;
    logic [7:0] crc_bit;
    logic [7:0] crc_byte;
`ifdef CRC_ZERO_FLAG_EN
    logic       crc_bit_ok;
    logic       crc_byte_ok;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp_bit;
        logic [7:0] exp_byte;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_bit;
    logic [7:0] m_byte;
    logic [7:0] frame [7];
    logic [7:0] saved;

    always #5 clk = ~clk;

    wimpfi_crc8_engine dut (
        .clk       (clk),
        .rst       (rst),
        .bit_enb   (bit_enb),
        .bit_d     (bit_d),
        .byte_enb  (byte_enb),
        .byte_data (byte_data),
        .crc_bit   (crc_bit),
        .crc_byte  (crc_byte)
`ifdef CRC_ZERO_FLAG_EN
        ,
        .crc_bit_ok  (crc_bit_ok),
        .crc_byte_ok (crc_byte_ok)
`endif
    );

    function automatic logic [7:0] step(input logic [7:0] c, input logic d);
        logic f;
        f = d ^ c[0];
        return (c >> 1) ^ (f ? 8'hE0 : 8'h00);
    endfunction

    function automatic logic [7:0] step_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = step(r, b[i]);
        return r;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag      = tag;
        e.exp_bit  = m_bit;
        e.exp_byte = m_byte;
        sb.push_back(e);
    endtask

    task automatic compare_sb();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check8({e.tag, "_bit"}, crc_bit, e.exp_bit);
            check8({e.tag, "_byte"}, crc_byte, e.exp_byte);
`ifdef CRC_ZERO_FLAG_EN
            check1({e.tag, "_bit_ok"}, crc_bit_ok, e.exp_bit == 8'h00);
            check1({e.tag, "_byte_ok"}, crc_byte_ok, e.exp_byte == 8'h00);
`endif
        end
    endtask

    task automatic cycle(input logic be, input logic bd, input logic ye, input logic [7:0] yd);
        @(negedge clk);
        bit_enb   = be;
        bit_d     = bd;
        byte_enb  = ye;
        byte_data = yd;
        if (be) m_bit = step(m_bit, bd);
        if (ye) m_byte = step_byte(m_byte, yd);
        @(posedge clk);
        #1;
        bit_enb   = 1'b0;
        byte_enb  = 1'b0;
        bit_d     = 1'bx;
        byte_data = 8'hxx;
    endtask

    task automatic feed_both(input logic [7:0] b);
        cycle(1'b1, b[0], 1'b1, b);
        for (int i = 1; i < 8; i++) cycle(1'b1, b[i], 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        m_bit  = 8'h00;
        m_byte = 8'h00;
        @(negedge clk);
        rst    = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        bit_enb   = 1'b0;
        byte_enb  = 1'b0;
        bit_d     = 1'b0;
        byte_data = 8'h00;
        m_bit     = 8'h00;
        m_byte    = 8'h00;
        frame[0]  = 8'h2A;
        frame[1]  = 8'h44;
        frame[2]  = 8'h31;
        for (int i = 3; i < 7; i++) frame[i] = 8'($urandom_range(0, 255));

        repeat (2) @(posedge clk);
        #1;
        push("reset");
        compare_sb();
        @(negedge clk);
        rst = 1'b1;

        // single byte 01, bitwise then bytewise
        for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0), 1'b0, 8'h00);
        push("byte01_bitwise");
        compare_sb();
        check8("spot_bit_01", crc_bit, 8'h91);
        cycle(1'b0, 1'b0, 1'b1, 8'h01);
        push("byte01_bytewise");
        compare_sb();
        check8("spot_byte_01", crc_byte, 8'h91);

        // X on data with enables low
        repeat (3) cycle(1'b0, 1'bx, 1'b0, 8'hxx);
        push("x_hold");
        compare_sb();

        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst    = 1'b0;
        m_bit  = 8'h00;
        m_byte = 8'h00;
        #1;
        push("async_rst");
        compare_sb();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        push("release_hold");
        compare_sb();

        // table corner: FF from zero
        cycle(1'b0, 1'b0, 1'b1, 8'hFF);
        push("byte_ff");
        compare_sb();

        // equivalence over the frame
        do_reset();
        for (int k = 0; k < 7; k++) begin
            feed_both(frame[k]);
            push($sformatf("equiv%0d", k));
            compare_sb();
        end

        // good residue
        saved = m_bit;
        feed_both(saved);
        push("residue_good");
        compare_sb();
        check8("residue_zero", crc_bit, 8'h00);

        // bad residue: inverted CRC appended
        do_reset();
        for (int k = 0; k < 7; k++) feed_both(frame[k]);
        feed_both(~saved);
        push("residue_bad");
        compare_sb();
        check1("residue_bad_nonzero", crc_bit != 8'h00, 1'b1);

        // reset in the middle of a byte
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h5A);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        m_bit  = 8'h00;
        m_byte = 8'h00;
        #1;
        push("midframe_rst");
        compare_sb();
        @(negedge clk);
        rst = 1'b1;
        feed_both(8'h01);
        push("restart01");
        compare_sb();
        check8("restart_spot", crc_byte, 8'h91);

        // simultaneous enables, independent updates
        cycle(1'b1, 1'b1, 1'b1, 8'hFF);
        push("simul");
        compare_sb();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h3C);
        push("indep");
        compare_sb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
